// File: rtl/nn_pkg.sv
// Shared types and helpers for the logit argmax block.
// Exports: state_t (IDLE/SCAN/DONE) and idx_w() to size class indices.
// No ports; imported by the interface, the compare cell and the top.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for n classes; never narrower than one bit so that a
  // single-class build still has a legal index port.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/logit_argmax_if.sv
// Request/result bundle for logit_argmax.
// master: drives start/logits, observes busy/done and the results.
// slave : the argmax engine side.
interface logit_argmax_if
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16
);
  localparam int IDX_W = idx_w(NUM_CLASSES);

  logic                          start;
  logic [NUM_CLASSES*DATA_W-1:0] logits;
  logic                          busy;
  logic                          done;
  logic [IDX_W-1:0]              class_idx;
  logic [DATA_W-1:0]             max_val;
  logic [IDX_W-1:0]              second_idx;
  logic [DATA_W-1:0]             second_val;
  logic [DATA_W-1:0]             margin;

  modport master (
    output start, logits,
    input  busy, done, class_idx, max_val, second_idx, second_val, margin
  );

  modport slave (
    input  start, logits,
    output busy, done, class_idx, max_val, second_idx, second_val, margin
  );

endinterface

// File: rtl/logit_cmp.sv
// Strict greater-than compare of two logits, signed or unsigned.
// Ports: a, b (DATA_W each) in; a_gt_b out, purely combinational.
// SIGNED_CMP=1 treats operands as two's complement, 0 as unsigned.
module logit_cmp #(
  parameter int DATA_W     = 16,
  parameter int SIGNED_CMP = 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              a_gt_b
);

  if (SIGNED_CMP != 0) begin : g_signed
    assign a_gt_b = $signed(a) > $signed(b);
  end else begin : g_unsigned
    assign a_gt_b = a > b;
  end

endmodule

// File: rtl/logit_argmax.sv
// Sequential argmax over NUM_CLASSES packed logits, one class per cycle.
// Ports: clk, rst (sync, active-high), bus (logit_argmax_if.slave):
//   start/logits in; busy, done, class_idx, max_val, second_idx,
//   second_val, margin out. done arrives NUM_CLASSES cycles after start.
// Optional runner-up/margin tracking: define LOGIT_ARGMAX_TOP2_EN.
module logit_argmax
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int SIGNED_CMP  = 1
) (
  input  logic          clk,
  input  logic          rst,
  logit_argmax_if.slave bus
);

  localparam int               IDX_W    = idx_w(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                        state, state_nxt;
  logic [NUM_CLASSES*DATA_W-1:0] snap;
  logic [IDX_W-1:0]              scan_idx;
  logic [DATA_W-1:0]             cur_val;
  logic                          cur_gt_best;
  logic                          accept;
  logic                          finish;

  logic [IDX_W-1:0]  best_idx, best_idx_nxt;
  logic [DATA_W-1:0] best_val, best_val_nxt;
  logic [IDX_W-1:0]  class_idx_q;
  logic [DATA_W-1:0] max_val_q;

  assign accept  = (state == IDLE) && bus.start;
  assign cur_val = snap[int'(scan_idx)*DATA_W +: DATA_W];

  logit_cmp #(
    .DATA_W     (DATA_W),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_cmp_best (
    .a      (cur_val),
    .b      (best_val),
    .a_gt_b (cur_gt_best)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (NUM_CLASSES == 1) ? DONE : SCAN;
      SCAN:    if (scan_idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results are latched on the edge that enters DONE, so they become
  // visible exactly in the done cycle and hold until the next one.
  assign finish = (state != DONE) && (state_nxt == DONE);

  // ---------------- running best ----------------
  always_comb begin
    best_idx_nxt = best_idx;
    best_val_nxt = best_val;
    if (accept) begin
      // Class 0 is taken straight from the input bus: the snapshot is
      // being written on the same edge.
      best_idx_nxt = '0;
      best_val_nxt = bus.logits[DATA_W-1:0];
    end else if (state == SCAN && cur_gt_best) begin
      best_idx_nxt = scan_idx;
      best_val_nxt = cur_val;
    end
  end

  // Snapshot only on an accepted start; never written during a scan.
  always_ff @(posedge clk) begin
    if (!rst && accept) snap <= bus.logits;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx    <= '0;
      best_idx    <= '0;
      best_val    <= '0;
      class_idx_q <= '0;
      max_val_q   <= '0;
    end else begin
      best_idx <= best_idx_nxt;
      best_val <= best_val_nxt;
      if (accept)             scan_idx <= IDX_W'(1);
      else if (state == SCAN) scan_idx <= scan_idx + IDX_W'(1);
      if (finish) begin
        class_idx_q <= best_idx_nxt;
        max_val_q   <= best_val_nxt;
      end
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.class_idx = class_idx_q;
  assign bus.max_val   = max_val_q;

  // ---------------- runner-up and margin ----------------
`ifdef LOGIT_ARGMAX_TOP2_EN
  localparam logic [DATA_W-1:0] MIN_VAL =
    (SIGNED_CMP != 0) ? (DATA_W'(1) << (DATA_W - 1)) : '0;

  logic [IDX_W-1:0]  sec_idx, sec_idx_nxt;
  logic [DATA_W-1:0] sec_val, sec_val_nxt;
  logic              cur_gt_sec;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] margin_nxt;
  logic [IDX_W-1:0]  second_idx_q;
  logic [DATA_W-1:0] second_val_q;
  logic [DATA_W-1:0] margin_q;

  logit_cmp #(
    .DATA_W     (DATA_W),
    .SIGNED_CMP (SIGNED_CMP)
  ) u_cmp_sec (
    .a      (cur_val),
    .b      (sec_val),
    .a_gt_b (cur_gt_sec)
  );

  always_comb begin
    sec_idx_nxt = sec_idx;
    sec_val_nxt = sec_val;
    if (accept) begin
      sec_idx_nxt = '0;
      sec_val_nxt = MIN_VAL;
    end else if (state == SCAN) begin
      if (cur_gt_best) begin
        // Dethroned best becomes the runner-up.
        sec_idx_nxt = best_idx;
        sec_val_nxt = best_val;
      end else if (cur_gt_sec) begin
        sec_idx_nxt = scan_idx;
        sec_val_nxt = cur_val;
      end
    end
  end

  // One extra bit holds the full difference; a set top bit means the
  // result does not fit DATA_W unsigned and is clamped to all-ones.
  always_comb begin
    if (SIGNED_CMP != 0)
      diff = {best_val_nxt[DATA_W-1], best_val_nxt} - {sec_val_nxt[DATA_W-1], sec_val_nxt};
    else
      diff = {1'b0, best_val_nxt} - {1'b0, sec_val_nxt};
    margin_nxt = diff[DATA_W] ? '1 : diff[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_idx      <= '0;
      sec_val      <= '0;
      second_idx_q <= '0;
      second_val_q <= '0;
      margin_q     <= '0;
    end else begin
      sec_idx <= sec_idx_nxt;
      sec_val <= sec_val_nxt;
      if (finish) begin
        second_idx_q <= sec_idx_nxt;
        second_val_q <= sec_val_nxt;
        margin_q     <= margin_nxt;
      end
    end
  end

  assign bus.second_idx = second_idx_q;
  assign bus.second_val = second_val_q;
  assign bus.margin     = margin_q;
`else
  assign bus.second_idx = '0;
  assign bus.second_val = '0;
  assign bus.margin     = '0;
`endif

endmodule

// File: tb/tb_logit_argmax.sv
// Directed bench for logit_argmax: signed and unsigned instances share stimulus.
// Expected values are hand-computed constants per step.
// Runner-up checks expect zeros when LOGIT_ARGMAX_TOP2_EN is undefined.
module tb_logit_argmax;
  import nn_pkg::*;

  localparam int NC = 10;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logit_argmax_if #(.NUM_CLASSES(NC), .DATA_W(DW)) bs ();
  logit_argmax_if #(.NUM_CLASSES(NC), .DATA_W(DW)) bu ();

  logit_argmax #(.NUM_CLASSES(NC), .DATA_W(DW), .SIGNED_CMP(1)) dut_s (
    .clk (clk), .rst (rst), .bus (bs.slave)
  );
  logit_argmax #(.NUM_CLASSES(NC), .DATA_W(DW), .SIGNED_CMP(0)) dut_u (
    .clk (clk), .rst (rst), .bus (bu.slave)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [NC*DW-1:0] lv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Runner-up results; tied to zero when tracking is compiled out.
  task automatic chk_second(input string tag, input logic [31:0] idx,
                            input logic [31:0] val, input logic [31:0] mar);
`ifdef LOGIT_ARGMAX_TOP2_EN
    chk({tag, "_sidx"}, 32'(bs.second_idx), idx);
    chk({tag, "_sval"}, 32'(bs.second_val), val);
    chk({tag, "_margin"}, 32'(bs.margin), mar);
`else
    chk({tag, "_sidx"}, 32'(bs.second_idx), 32'd0);
    chk({tag, "_sval"}, 32'(bs.second_val), 32'd0);
    chk({tag, "_margin"}, 32'(bs.margin), 32'd0);
    if (idx === 32'hFFFF_FFFF || val === 32'hFFFF_FFFF || mar === 32'hFFFF_FFFF) ;
`endif
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [DW-1:0] v);
    for (int k = 0; k < NC; k++) lv[k*DW +: DW] = v;
  endtask

  task automatic set_cls(input int k, input logic [DW-1:0] v);
    lv[k*DW +: DW] = v;
  endtask

  // Presents lv with a one-cycle start (cycle T); returns in cycle T+1.
  task automatic launch;
    bs.logits = lv;
    bu.logits = lv;
    bs.start  = 1'b1;
    bu.start  = 1'b1;
    step;
    bs.start  = 1'b0;
    bu.start  = 1'b0;
  endtask

  // Steps until done, lat = cycles after the start cycle; bounded.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (bs.done !== 1'b1 && lat < 40) begin
      step;
      lat++;
    end
  endtask

  initial begin
    int   lat;
    int   g;
    logic seen;

    rst = 1'b1;
    bs.start = 1'b0; bu.start = 1'b0;
    lv = '0;
    bs.logits = '0; bu.logits = '0;
    step; step;

    // Reset state
    chk("rst_done", 32'(bs.done), 32'd0);
    chk("rst_busy", 32'(bs.busy), 32'd0);
    chk("rst_cidx", 32'(bs.class_idx), 32'd0);
    chk("rst_max", 32'(bs.max_val), 32'd0);
    chk_second("rst", 32'd0, 32'd0, 32'd0);
    rst = 1'b0;
    step;

    // Default pattern; logits changed after start must not matter
    set_all(16'h0010);
    set_cls(3, 16'h0400);
    launch;
    bs.logits[8*DW +: DW] = 16'h7000;
    bu.logits[8*DW +: DW] = 16'h7000;
    chk("a_busy_scan", 32'(bs.busy), 32'd1);
    chk("a_nodone_t1", 32'(bs.done), 32'd0);
    wait_done(1, lat);
    chk("a_latency", 32'(lat), 32'd10);
    chk("a_cidx", 32'(bs.class_idx), 32'd3);
    chk("a_max", 32'(bs.max_val), 32'h0400);
    chk_second("a", 32'd0, 32'h0010, 32'h03F0);
    chk("a_u_done", 32'(bu.done), 32'd1);
    chk("a_u_cidx", 32'(bu.class_idx), 32'd3);
    step;
    chk("a_done_pulse", 32'(bs.done), 32'd0);
    chk("a_busy_idle", 32'(bs.busy), 32'd0);
    chk("a_hold_cidx", 32'(bs.class_idx), 32'd3);

    // Tie resolves to the lowest index
    set_all(16'h0000);
    set_cls(2, 16'h7FFF);
    set_cls(7, 16'h7FFF);
    launch;
    wait_done(1, lat);
    chk("tie_latency", 32'(lat), 32'd10);
    chk("tie_cidx", 32'(bs.class_idx), 32'd2);
    chk("tie_max", 32'(bs.max_val), 32'h7FFF);
    chk_second("tie", 32'd7, 32'h7FFF, 32'd0);
    step;

    // Negative logits: 0xFFFF wins both signed and unsigned
    set_all(16'h8000);
    set_cls(5, 16'hFFFF);
    launch;
    wait_done(1, lat);
    chk("neg_cidx_s", 32'(bs.class_idx), 32'd5);
    chk("neg_max_s", 32'(bs.max_val), 32'hFFFF);
    chk("neg_cidx_u", 32'(bu.class_idx), 32'd5);
    chk_second("neg", 32'd0, 32'h8000, 32'h7FFF);
    step;

    // Signedness splits the winner
    set_all(16'h0000);
    set_cls(9, 16'h8001);
    set_cls(5, 16'h0001);
    launch;
    wait_done(1, lat);
    chk("sgn_cidx_s", 32'(bs.class_idx), 32'd5);
    chk("sgn_max_s", 32'(bs.max_val), 32'h0001);
    chk("sgn_cidx_u", 32'(bu.class_idx), 32'd9);
    chk("sgn_max_u", 32'(bu.max_val), 32'h8001);
    chk_second("sgn", 32'd0, 32'h0000, 32'h0001);
`ifdef LOGIT_ARGMAX_TOP2_EN
    chk("sgn_u_sidx", 32'(bu.second_idx), 32'd5);
    chk("sgn_u_margin", 32'(bu.margin), 32'h8000);
`endif
    step;

    // Widest signed margin
    set_all(16'h8000);
    set_cls(0, 16'h7FFF);
    launch;
    wait_done(1, lat);
    chk("sat_cidx", 32'(bs.class_idx), 32'd0);
    chk("sat_max", 32'(bs.max_val), 32'h7FFF);
    chk_second("sat", 32'd0, 32'h8000, 32'hFFFF);
    step;

    // Reset mid-scan at T+4 (start held with it), restart at T+6
    seen = 1'b0;
    launch;                                   // now T+1
    seen = seen | bs.done;
    step; seen = seen | bs.done;              // T+2
    step; seen = seen | bs.done;              // T+3
    step; seen = seen | bs.done;              // T+4
    rst = 1'b1; bs.start = 1'b1; bu.start = 1'b1;
    step; seen = seen | bs.done;              // T+5
    rst = 1'b0; bs.start = 1'b0; bu.start = 1'b0;
    chk("rstm_no_done", 32'(seen), 32'd0);
    chk("rstm_busy", 32'(bs.busy), 32'd0);
    chk("rstm_cidx", 32'(bs.class_idx), 32'd0);
    chk("rstm_max", 32'(bs.max_val), 32'd0);
    chk_second("rstm", 32'd0, 32'd0, 32'd0);
    step;                                     // T+6
    launch;
    wait_done(1, lat);
    chk("rstm_restart_lat", 32'(lat), 32'd10);
    chk("rstm_restart_cidx", 32'(bs.class_idx), 32'd0);
    chk("rstm_restart_max", 32'(bs.max_val), 32'h7FFF);
    step;

    // Back-to-back: stray start at T+3 ignored, restart in IDLE after done
    set_all(16'h0010);
    set_cls(3, 16'h0400);
    launch;                                   // T+1
    step;                                     // T+2
    step;                                     // T+3
    set_cls(3, 16'h0001);
    set_cls(6, 16'h0500);
    bs.logits = lv; bu.logits = lv;
    bs.start = 1'b1; bu.start = 1'b1;
    step;                                     // T+4
    bs.start = 1'b0; bu.start = 1'b0;
    wait_done(4, lat);
    chk("b2b_first_lat", 32'(lat), 32'd10);
    chk("b2b_first_cidx", 32'(bs.class_idx), 32'd3);
    g = 0;
    step; g++;                                // T+11, IDLE
    chk("b2b_idle_done", 32'(bs.done), 32'd0);
    chk("b2b_idle_busy", 32'(bs.busy), 32'd0);
    bs.start = 1'b1; bu.start = 1'b1;
    step; g++;
    bs.start = 1'b0; bu.start = 1'b0;
    while (bs.done !== 1'b1 && g < 40) begin
      step;
      g++;
    end
    chk("b2b_gap", 32'(g), 32'd11);
    chk("b2b_second_cidx", 32'(bs.class_idx), 32'd6);
    chk("b2b_second_max", 32'(bs.max_val), 32'h0500);
    step;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
